// File: rtl/alu_issue_queue_pkg.sv
// alu_issue_queue_pkg
//   Shared widths and field layout for the ALU issue queue.
//   - IQ_CNTRL_SIZE : ALU control word width
//   - IQ_CTL_*      : bit positions inside the control word as decoded by the ALU
//   - IQ_LNCOMMIT   : commit/rename tag width
//   - iq_hart_width : hart field width (a single hart still carries a 1-bit field)
package alu_issue_queue_pkg;

  localparam int IQ_CNTRL_SIZE = 7;
  localparam int IQ_LNCOMMIT   = 5;

  // Control word layout: [3:0] opcode, [4] subtract/arith-shift, [5] 32-bit op, [6] immediate operand
  localparam int IQ_CTL_OP_LSB  = 0;
  localparam int IQ_CTL_OP_W    = 4;
  localparam int IQ_CTL_SUB_BIT = 4;
  localparam int IQ_CTL_W32_BIT = 5;
  localparam int IQ_CTL_IMM_BIT = 6;

  function automatic int iq_hart_width(input int nhart, input int lnhart);
    return (nhart == 1) ? 1 : lnhart;
  endfunction

endpackage

// File: rtl/alu_iq_pick.sv
// alu_iq_pick
//   Lowest-index-first picker over the eligible vector.
//   - eligible : one bit per queue entry
//   - grant    : one-hot of the lowest set eligible bit (all zero if none)
//   - idx      : binary index of the granted entry (0 if none)
//   - any      : at least one entry is eligible
module alu_iq_pick #(
  parameter  int N  = 8,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  eligible,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    // Two's-complement trick isolates the lowest set bit.
    grant = eligible & (~eligible + N'(1));
    any   = |eligible;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (eligible[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/alu_issue_queue.sv
// alu_issue_queue
//   Age-ordered, compacting reservation queue feeding one ALU.
//   Ports:
//   - clk / reset          : clock, synchronous active-high reset
//   - in_*                 : renamed op offered for insert (in_valid/in_ready handshake)
//   - wake_valid / wake_rd : result-tag broadcasts, port 0 is this ALU's own result
//   - commit_kill_0        : per-destination-tag squash bits
//   - alu_*                : oldest eligible op, combinational from registered state
//   - count                : registered number of occupied entries
module alu_issue_queue
  import alu_issue_queue_pkg::*;
#(
  parameter  int NENT       = 8,
  parameter  int CNTRL_SIZE = IQ_CNTRL_SIZE,
  parameter  int RV         = 64,
  parameter  int NCOMMIT    = 32,
  parameter  int LNCOMMIT   = IQ_LNCOMMIT,
  parameter  int NHART      = 1,
  parameter  int LNHART     = 0,
  parameter  int NWAKE      = 2,
  localparam int HW         = iq_hart_width(NHART, LNHART),
  localparam int CW         = $clog2(NENT + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CNTRL_SIZE-1:0]     in_control,
  input  logic [LNCOMMIT-1:0]       in_rd,
  input  logic                      in_makes_rd,
  input  logic                      in_needs_rs2,
  input  logic [LNCOMMIT-1:0]       in_rs1,
  input  logic [LNCOMMIT-1:0]       in_rs2,
  input  logic                      in_rs1_ready,
  input  logic                      in_rs2_ready,
  input  logic [RV-1:1]             in_pc,
  input  logic [31:0]               in_immed,
  input  logic [HW-1:0]             in_hart,
  input  logic [NWAKE-1:0]          wake_valid,
  input  logic [NWAKE*LNCOMMIT-1:0] wake_rd,
  input  logic [NCOMMIT-1:0]        commit_kill_0,
  output logic                      alu_enable,
  output logic [CNTRL_SIZE-1:0]     alu_control,
  output logic [LNCOMMIT-1:0]       alu_rd,
  output logic                      alu_makes_rd,
  output logic                      alu_needs_rs2,
  output logic [RV-1:1]             alu_pc,
  output logic [31:0]               alu_immed,
  output logic [HW-1:0]             alu_hart,
  output logic [LNCOMMIT-1:0]       alu_rs1,
  output logic [LNCOMMIT-1:0]       alu_rs2,
  output logic [CW-1:0]             count
);

  localparam int IW = (NENT > 1) ? $clog2(NENT) : 1;

  logic [NENT-1:0]       valid_q, valid_d, rdy1_q, rdy1_d, rdy2_q, rdy2_d;
  logic [NENT-1:0]       makes_rd_q, makes_rd_d, needs_rs2_q, needs_rs2_d;
  logic [CNTRL_SIZE-1:0] control_q [NENT];
  logic [CNTRL_SIZE-1:0] control_d [NENT];
  logic [LNCOMMIT-1:0]   rd_q  [NENT];
  logic [LNCOMMIT-1:0]   rd_d  [NENT];
  logic [LNCOMMIT-1:0]   rs1_q [NENT];
  logic [LNCOMMIT-1:0]   rs1_d [NENT];
  logic [LNCOMMIT-1:0]   rs2_q [NENT];
  logic [LNCOMMIT-1:0]   rs2_d [NENT];
  logic [RV-1:1]         pc_q  [NENT];
  logic [RV-1:1]         pc_d  [NENT];
  logic [31:0]           immed_q [NENT];
  logic [31:0]           immed_d [NENT];
  logic [HW-1:0]         hart_q  [NENT];
  logic [HW-1:0]         hart_d  [NENT];
  logic [CW-1:0]         count_q, count_d;

  logic [NENT-1:0] kill, eligible, survive, woke1, woke2, grant;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic            accept;

  function automatic logic tag_woken(input logic [LNCOMMIT-1:0] tag);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < NWAKE; k++) begin
      if (wake_valid[k] && (wake_rd[k*LNCOMMIT +: LNCOMMIT] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  // Issue eligibility uses registered ready flags only: a wakeup this cycle
  // makes the entry issuable next cycle, never in the same one.
  for (genvar gi = 0; gi < NENT; gi++) begin : g_ent
    assign kill[gi]     = commit_kill_0[rd_q[gi]];
    assign woke1[gi]    = tag_woken(rs1_q[gi]);
    assign woke2[gi]    = tag_woken(rs2_q[gi]);
    assign eligible[gi] = valid_q[gi] & rdy1_q[gi] & rdy2_q[gi] & ~kill[gi];
    assign survive[gi]  = valid_q[gi] & ~grant[gi] & ~kill[gi];
  end

  alu_iq_pick #(.N(NENT)) u_pick (
    .eligible (eligible),
    .grant    (grant),
    .idx      (pick_idx),
    .any      (pick_any)
  );

  assign in_ready = ~reset & (count_q < CW'(NENT));
  assign accept   = in_valid & in_ready;

  // Compaction: each survivor lands at the running count of survivors below it;
  // the accepted op follows the last survivor.
  always_comb begin
    logic [CW-1:0] slot;
    valid_d     = '0;
    rdy1_d      = rdy1_q;
    rdy2_d      = rdy2_q;
    makes_rd_d  = makes_rd_q;
    needs_rs2_d = needs_rs2_q;
    control_d   = control_q;
    rd_d        = rd_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    pc_d        = pc_q;
    immed_d     = immed_q;
    hart_d      = hart_q;
    slot        = '0;
    for (int i = 0; i < NENT; i++) begin
      if (survive[i]) begin
        valid_d[slot[IW-1:0]]     = 1'b1;
        rdy1_d[slot[IW-1:0]]      = rdy1_q[i] | woke1[i];
        rdy2_d[slot[IW-1:0]]      = rdy2_q[i] | woke2[i];
        makes_rd_d[slot[IW-1:0]]  = makes_rd_q[i];
        needs_rs2_d[slot[IW-1:0]] = needs_rs2_q[i];
        control_d[slot[IW-1:0]]   = control_q[i];
        rd_d[slot[IW-1:0]]        = rd_q[i];
        rs1_d[slot[IW-1:0]]       = rs1_q[i];
        rs2_d[slot[IW-1:0]]       = rs2_q[i];
        pc_d[slot[IW-1:0]]        = pc_q[i];
        immed_d[slot[IW-1:0]]     = immed_q[i];
        hart_d[slot[IW-1:0]]      = hart_q[i];
        slot                      = slot + CW'(1);
      end
    end
    // A killed insert is accepted by the handshake but never stored.
    if (accept && !commit_kill_0[in_rd] && (slot < CW'(NENT))) begin
      valid_d[slot[IW-1:0]]     = 1'b1;
      rdy1_d[slot[IW-1:0]]      = in_rs1_ready | tag_woken(in_rs1);
      rdy2_d[slot[IW-1:0]]      = ~in_needs_rs2 | in_rs2_ready | tag_woken(in_rs2);
      makes_rd_d[slot[IW-1:0]]  = in_makes_rd;
      needs_rs2_d[slot[IW-1:0]] = in_needs_rs2;
      control_d[slot[IW-1:0]]   = in_control;
      rd_d[slot[IW-1:0]]        = in_rd;
      rs1_d[slot[IW-1:0]]       = in_rs1;
      rs2_d[slot[IW-1:0]]       = in_rs2;
      pc_d[slot[IW-1:0]]        = in_pc;
      immed_d[slot[IW-1:0]]     = in_immed;
      hart_d[slot[IW-1:0]]      = in_hart;
      slot                      = slot + CW'(1);
    end
    count_d = slot;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  // Payload is only meaningful under valid_q, so it carries no reset.
  always_ff @(posedge clk) begin
    rdy1_q      <= rdy1_d;
    rdy2_q      <= rdy2_d;
    makes_rd_q  <= makes_rd_d;
    needs_rs2_q <= needs_rs2_d;
    control_q   <= control_d;
    rd_q        <= rd_d;
    rs1_q       <= rs1_d;
    rs2_q       <= rs2_d;
    pc_q        <= pc_d;
    immed_q     <= immed_d;
    hart_q      <= hart_d;
  end

  assign alu_enable    = pick_any & ~reset;
  assign alu_control   = control_q[pick_idx];
  assign alu_rd        = rd_q[pick_idx];
  assign alu_makes_rd  = makes_rd_q[pick_idx];
  assign alu_needs_rs2 = needs_rs2_q[pick_idx];
  assign alu_pc        = pc_q[pick_idx];
  assign alu_immed     = immed_q[pick_idx];
  assign alu_hart      = hart_q[pick_idx];
  assign alu_rs1       = rs1_q[pick_idx];
  assign alu_rs2       = rs2_q[pick_idx];
  assign count         = count_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
module tb_alu_issue_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [6:0]  in_control;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic        in_makes_rd, in_needs_rs2, in_rs1_ready, in_rs2_ready;
  logic [63:1] in_pc;
  logic [31:0] in_immed;
  logic [0:0]  in_hart;
  logic [1:0]  wake_valid;
  logic [9:0]  wake_rd;
  logic [31:0] commit_kill_0;
  logic        alu_enable, alu_makes_rd, alu_needs_rs2;
  logic [6:0]  alu_control;
  logic [4:0]  alu_rd, alu_rs1, alu_rs2;
  logic [63:1] alu_pc;
  logic [31:0] alu_immed;
  logic [0:0]  alu_hart;
  logic [3:0]  count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_issue_queue dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_control(in_control), .in_rd(in_rd), .in_makes_rd(in_makes_rd),
    .in_needs_rs2(in_needs_rs2), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rs1_ready(in_rs1_ready), .in_rs2_ready(in_rs2_ready), .in_pc(in_pc),
    .in_immed(in_immed), .in_hart(in_hart), .wake_valid(wake_valid),
    .wake_rd(wake_rd), .commit_kill_0(commit_kill_0), .alu_enable(alu_enable),
    .alu_control(alu_control), .alu_rd(alu_rd), .alu_makes_rd(alu_makes_rd),
    .alu_needs_rs2(alu_needs_rs2), .alu_pc(alu_pc), .alu_immed(alu_immed),
    .alu_hart(alu_hart), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .count(count)
  );

  typedef struct {
    logic        iv;
    logic [4:0]  rd, rs1, rs2;
    logic        r1, r2, nrs2;
    logic        w0v;
    logic [4:0]  w0;
    logic        w1v;
    logic [4:0]  w1;
    logic [31:0] kill;
    logic        en;
    logic [4:0]  erd;
    int          cnt;
    logic        rdy;
  } vec_t;

  function automatic vec_t mk(input logic iv, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic r1, input logic [4:0] rs2, input logic r2,
                              input logic nrs2, input logic w0v, input logic [4:0] w0,
                              input logic w1v, input logic [4:0] w1, input logic [31:0] kill,
                              input logic en, input logic [4:0] erd, input int cnt,
                              input logic rdy);
    vec_t v;
    v.iv = iv; v.rd = rd; v.rs1 = rs1; v.r1 = r1; v.rs2 = rs2; v.r2 = r2; v.nrs2 = nrs2;
    v.w0v = w0v; v.w0 = w0; v.w1v = w1v; v.w1 = w1; v.kill = kill;
    v.en = en; v.erd = erd; v.cnt = cnt; v.rdy = rdy;
    return v;
  endfunction

  function automatic vec_t idle(input logic en, input logic [4:0] erd, input int cnt);
    return mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, en, erd, cnt, 1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle's inputs, check the same cycle's outputs, then advance past the edge.
  task automatic run(input string tag, input vec_t v);
    in_valid      = v.iv;
    in_rd         = v.rd;
    in_rs1        = v.rs1;
    in_rs2        = v.rs2;
    in_rs1_ready  = v.r1;
    in_rs2_ready  = v.r2;
    in_needs_rs2  = v.nrs2;
    in_makes_rd   = 1'b1;
    in_control    = 7'(v.rd) ^ 7'h55;
    in_immed      = 32'hA500_0000 | 32'(v.rd);
    in_pc         = 63'(v.rd) << 4;
    in_hart       = 1'b0;
    wake_valid    = {v.w1v, v.w0v};
    wake_rd       = {v.w1, v.w0};
    commit_kill_0 = v.kill;
    #1;
    $display("%s: iv=%0d rd=%0d en=%0d alu_rd=%0d count=%0d in_ready=%0d",
             tag, v.iv, v.rd, alu_enable, alu_rd, count, in_ready);
    chk({tag, " alu_enable"}, 32'(alu_enable), 32'(v.en));
    if (v.en) begin
      chk({tag, " alu_rd"}, 32'(alu_rd), 32'(v.erd));
      chk({tag, " alu_control"}, 32'(alu_control), 32'(7'(v.erd) ^ 7'h55));
      chk({tag, " alu_immed"}, alu_immed, 32'hA500_0000 | 32'(v.erd));
    end
    chk({tag, " count"}, 32'(count), 32'(v.cnt));
    chk({tag, " in_ready"}, 32'(in_ready), 32'(v.rdy));
    @(posedge clk);
    #1;
  endtask

  vec_t vecs [20];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0]  = mk(1, 3, 1, 1, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    vecs[1]  = idle(1, 3, 1);
    vecs[2]  = idle(0, 0, 0);
    vecs[3]  = mk(1, 4, 9, 0, 10, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    vecs[4]  = mk(1, 5, 11, 1, 12, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    vecs[5]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 9, 0, 0, 0, 1, 5, 2, 1);
    vecs[6]  = idle(1, 4, 1);
    vecs[7]  = idle(0, 0, 0);
    vecs[8]  = mk(1, 8, 7, 0, 13, 1, 1, 0, 0, 1, 7, 0, 0, 0, 0, 1);
    vecs[9]  = idle(1, 8, 1);
    vecs[10] = idle(0, 0, 0);
    vecs[11] = mk(1, 14, 15, 1, 30, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    vecs[12] = idle(1, 14, 1);
    vecs[13] = idle(0, 0, 0);
    vecs[14] = mk(1, 16, 17, 0, 18, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    vecs[15] = mk(0, 0, 0, 0, 0, 0, 1, 1, 17, 0, 0, 0, 0, 0, 1, 1);
    vecs[16] = idle(1, 16, 1);
    vecs[17] = idle(0, 0, 0);
    vecs[18] = mk(1, 20, 21, 1, 22, 1, 1, 0, 0, 0, 0, 32'h1 << 20, 0, 0, 0, 1);
    vecs[19] = idle(0, 0, 0);

    reset = 1'b1;
    in_valid = 0; in_rd = 0; in_rs1 = 0; in_rs2 = 0; in_rs1_ready = 0; in_rs2_ready = 0;
    in_needs_rs2 = 0; in_makes_rd = 0; in_control = 0; in_immed = 0; in_pc = 0; in_hart = 0;
    wake_valid = 0; wake_rd = 0; commit_kill_0 = 0;
    repeat (2) @(posedge clk);
    #1;
    $display("reset: en=%0d count=%0d in_ready=%0d", alu_enable, count, in_ready);
    chk("reset alu_enable", 32'(alu_enable), 32'd0);
    chk("reset count", 32'(count), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) run($sformatf("vec%0d", i), vecs[i]);

    // Fill all eight entries with ops blocked on tag 25.
    for (int k = 0; k < 8; k++)
      run($sformatf("fill%0d", k), mk(1, 5'(k + 1), 25, 0, 26, 1, 1, 0, 0, 0, 0, 0, 0, 0, k, 1));
    // Full: offered op is refused; broadcast tag 25 wakes everyone.
    run("full_wake", mk(1, 31, 1, 1, 2, 1, 1, 1, 25, 0, 0, 0, 0, 0, 8, 0));
    // First issue while still full: in_ready stays low.
    run("drain1", mk(1, 31, 1, 1, 2, 1, 1, 0, 0, 0, 0, 0, 1, 1, 8, 0));
    for (int k = 2; k <= 8; k++)
      run($sformatf("drain%0d", k), idle(1, 5'(k), 9 - k));
    run("drain_done", idle(0, 0, 0));

    // Kill of the picked entry switches the pick to the next-oldest the same cycle.
    run("kill_ins2", mk(1, 2, 27, 0, 28, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    run("kill_ins6", mk(1, 6, 27, 0, 28, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    run("kill_wake", mk(0, 0, 0, 0, 0, 0, 1, 1, 27, 0, 0, 0, 0, 0, 2, 1));
    run("kill_pick", mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h1 << 2, 1, 6, 2, 1));
    run("kill_after", idle(0, 0, 0));

    // Reset mid-operation discards the queued entry and the concurrent wakeup.
    run("rst_ins", mk(1, 9, 29, 0, 28, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    reset = 1'b1;
    run("rst_mid", mk(0, 0, 0, 0, 0, 0, 1, 1, 29, 0, 0, 0, 0, 0, 1, 0));
    reset = 1'b0;
    run("rst_post", idle(0, 0, 0));
    run("rst_post2", idle(0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
